brc_ctrl: RTL

Branch resolution controller for the pipelined RV32I core. Sits in EX beside the branch comparator. It drives the comparator's unsigned-select, turns the less/equal flags plus the instruction class into a taken decision, and registers that decision. One cycle later it issues a PC redirect and a three-register pipeline squash. It also keeps resolved-branch and taken-branch counters for the performance CSRs.

---
 rtl/brc_pkg.sv | 21 ++
 rtl/br_cond.sv | 31 +++
 rtl/brc_ctrl.sv | 116 +++++++++++
 3 files changed

// File: rtl/brc_pkg.sv
// Shared definitions for the branch resolution controller.
//   - funct3 encodings of the RV32I conditional branches
//   - FSM state type for brc_ctrl
//   - default width of the performance counters
package brc_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam int unsigned CNT_W_DEFAULT = 32;

  typedef enum logic {
    ST_IDLE,
    ST_REDIRECT
  } brc_state_e;

endpackage

// File: rtl/br_cond.sv
// Branch condition decode. Turns the comparator flags and a branch funct3
// into a taken condition. Purely combinational.
// Ports:
//   i_funct3    branch funct3
//   i_less      comparator less-than flag (signedness chosen upstream)
//   i_equal     comparator equality flag
//   o_cond      branch condition holds
//   o_valid_f3  funct3 is a defined branch encoding
module br_cond
  import brc_pkg::*;
(
  input  logic [2:0] i_funct3,
  input  logic       i_less,
  input  logic       i_equal,
  output logic       o_cond,
  output logic       o_valid_f3
);

  always_comb begin
    o_cond     = 1'b0;
    o_valid_f3 = 1'b1;
    case (i_funct3)
      F3_BEQ:           o_cond = i_equal;
      F3_BNE:           o_cond = ~i_equal;
      F3_BLT, F3_BLTU:  o_cond = i_less;
      F3_BGE, F3_BGEU:  o_cond = ~i_less;
      default:          o_valid_f3 = 1'b0;
    endcase
  end

endmodule

// File: rtl/brc_ctrl.sv
// Branch resolution controller in EX. Selects comparator signedness, decides
// taken, and one cycle later issues a PC redirect plus a squash of IF/ID,
// ID/EX and EX/MEM. Keeps resolved and taken conditional-branch counters.
// Ports:
//   i_clk, i_reset        clock, synchronous active-high reset
//   i_stall               global pipeline freeze
//   i_ex_valid            EX holds a live instruction
//   i_ex_is_branch        B-type in EX
//   i_ex_is_jump          JAL/JALR in EX
//   i_ex_funct3           branch funct3
//   i_ex_target           computed branch/jump target
//   i_br_less, i_br_equal comparator flags
//   o_br_uns              comparator unsigned select (combinational)
//   o_pc_sel              PC mux takes o_pc_target
//   o_pc_target           registered redirect target
//   o_flush_*             squash the named pipeline register at next edge
//   o_br_count            resolved conditional branches
//   o_taken_count         taken conditional branches
module brc_ctrl
  import brc_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_stall,
  input  logic             i_ex_valid,
  input  logic             i_ex_is_branch,
  input  logic             i_ex_is_jump,
  input  logic [2:0]       i_ex_funct3,
  input  logic [XLEN-1:0]  i_ex_target,
  input  logic             i_br_less,
  input  logic             i_br_equal,
  output logic             o_br_uns,
  output logic             o_pc_sel,
  output logic [XLEN-1:0]  o_pc_target,
  output logic             o_flush_if_id,
  output logic             o_flush_id_ex,
  output logic             o_flush_ex_mem,
  output logic [CNT_W-1:0] o_br_count,
  output logic [CNT_W-1:0] o_taken_count
);

  logic w_cond;
  logic w_valid_f3;
  logic w_take;
  logic w_count;

  brc_state_e       r_state;
  logic             r_redirect;
  logic [XLEN-1:0]  r_pc_target;
  logic [CNT_W-1:0] r_br_count;
  logic [CNT_W-1:0] r_taken_count;

  br_cond u_br_cond (
    .i_funct3   (i_ex_funct3),
    .i_less     (i_br_less),
    .i_equal    (i_br_equal),
    .o_cond     (w_cond),
    .o_valid_f3 (w_valid_f3)
  );

  assign o_br_uns = (i_ex_funct3 == F3_BLTU) || (i_ex_funct3 == F3_BGEU);

  assign w_take  = i_ex_valid & (i_ex_is_jump | (i_ex_is_branch & w_cond));
  assign w_count = i_ex_valid & i_ex_is_branch & w_valid_f3;

  // r_redirect mirrors ST_REDIRECT so the redirect/flush outputs come straight
  // from a flop, with no path from the comparator flags.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state       <= ST_IDLE;
      r_redirect    <= 1'b0;
      r_pc_target   <= '0;
      r_br_count    <= '0;
      r_taken_count <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (!i_stall) begin
            if (w_take) begin
              r_pc_target <= i_ex_target;
              r_redirect  <= 1'b1;
              r_state     <= ST_REDIRECT;
            end
            if (w_count) begin
              r_br_count <= r_br_count + CNT_W'(1);
              if (w_cond) r_taken_count <= r_taken_count + CNT_W'(1);
            end
          end
        end
        ST_REDIRECT: begin
          // Whatever sits in EX now is wrong-path: no capture, no count.
          if (!i_stall) begin
            r_redirect <= 1'b0;
            r_state    <= ST_IDLE;
          end
        end
        default: begin
          r_redirect <= 1'b0;
          r_state    <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_pc_sel       = r_redirect;
  assign o_flush_if_id  = r_redirect;
  assign o_flush_id_ex  = r_redirect;
  assign o_flush_ex_mem = r_redirect;
  assign o_pc_target    = r_pc_target;
  assign o_br_count     = r_br_count;
  assign o_taken_count  = r_taken_count;

endmodule
